fpga_led_pssr: RTL and testbench

FPGA_LED_PSSR -- requirements
Module: fpga_led_pssr

---
 rtl/fpga_led_pkg.sv | 21 ++
 rtl/led_frame_reg.sv | 40 ++++
 rtl/fpga_led_pssr.sv | 71 +++++++
 tb/tb_fpga_led_pssr.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_led_pkg.sv
// Shared constants and types for the LED parallel-to-serial frame shifter.
package fpga_led_pkg;

    // Default frame length in bits.
    localparam int unsigned LED_WIDTH = 32;

    // Bit-counter width for the default frame length.
    localparam int unsigned LED_CNT_W = $clog2(LED_WIDTH);

    // Frame identifiers; the value matches the sel input encoding.
    typedef enum logic {
        FRAME_A = 1'b0,
        FRAME_B = 1'b1
    } frame_sel_e;

    // Counter width for an arbitrary frame length (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/led_frame_reg.sv
// One frame shadow register: parallel load, enable-gated right rotate (LSB out
// first), modulo-WIDTH bit counter and a flag for the last bit of the frame.
// WIDTH must be at least 2.
module led_frame_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;

    // Load takes priority over rotation; rotation advances the bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking so the data and counter both update from pre-edge values.
            r_data <= i_data;
            r_cnt  <= '0;
        end else if (i_en) begin
            r_data <= {r_data[0], r_data[WIDTH-1:1]};
            r_cnt  <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit  = r_data[0];
    assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/fpga_led_pssr.sv
// Two-frame LED serializer: frames A and B are loaded together, and the frame
// chosen by sel drives the serial output and rotates; the other frame keeps
// its position so it resumes where it left off when selected again.
module fpga_led_pssr
    import fpga_led_pkg::*;
#(
    parameter int unsigned WIDTH = LED_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] rB,
    input  logic             sel,
    output logic             data_out,
    output logic             frame_done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    frame_sel_e w_sel;
    logic       w_en_a;
    logic       w_en_b;
    logic       w_bit_a;
    logic       w_bit_b;
    logic       w_last_a;
    logic       w_last_b;

    assign w_sel  = frame_sel_e'(sel);
    assign w_en_a = ~load & (w_sel == FRAME_A);
    assign w_en_b = ~load & (w_sel == FRAME_B);

    led_frame_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_a (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (load),
        .i_en    (w_en_a),
        .i_data  (rA),
        .o_bit   (w_bit_a),
        .o_last  (w_last_a)
    );

    led_frame_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_b (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (load),
        .i_en    (w_en_b),
        .i_data  (rB),
        .o_bit   (w_bit_b),
        .o_last  (w_last_b)
    );

    // Output mux follows sel immediately; frame_done is masked while loading.
    always_comb begin
        data_out   = w_bit_a;
        frame_done = 1'b0;
        if (w_sel == FRAME_B) begin
            data_out   = w_bit_b;
            frame_done = ~load & w_last_b;
        end else begin
            frame_done = ~load & w_last_a;
        end
    end

endmodule

// File: tb/tb_fpga_led_pssr.sv
// Self-checking bench for fpga_led_pssr: directed frame scenarios plus random
// traffic, compared against a frame/position model of the two LED frames.
module tb_fpga_led_pssr;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] rA = '0;
    logic [W-1:0] rB = '0;
    logic         data_out;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each frame is its loaded word plus the index of the bit on show.
    logic [W-1:0] m_frame [2];
    int           m_pos   [2];

    fpga_led_pssr #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .rA         (rA),
        .rB         (rB),
        .sel        (sel),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic m_data();
        int s = int'(sel);
        return m_frame[s][m_pos[s]];
    endfunction

    function automatic logic m_done();
        int s = int'(sel);
        return !load && (m_pos[s] == W - 1);
    endfunction

    task automatic m_reset();
        for (int f = 0; f < 2; f++) begin
            m_frame[f] = '0;
            m_pos[f]   = 0;
        end
    endtask

    // Advance one clock: update the model with the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (load) begin
                m_frame[0] = rA;
                m_frame[1] = rB;
                m_pos[0]   = 0;
                m_pos[1]   = 0;
            end else begin
                m_pos[int'(sel)] = (m_pos[int'(sel)] + 1) % W;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b1;
        rA   = 32'hB;
        rB   = 32'h9;
        sel  = 1'($urandom_range(0, 1));
        m_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (data_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset data_out cycle %0d actual=%b required=0", i, data_out);
            end
            n_checks++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset frame_done cycle %0d actual=%b required=0", i, frame_done);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release outputs actual=%b%b required=00", data_out, frame_done);
        end
        tick();
        load = 1'b0;
        sel  = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_load data_out actual=%b required=1", data_out);
        end
    endtask

    task automatic test_frame_a();
        logic [W-1:0] pat = 32'hB;
        load = 1'b0;
        sel  = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            #1;
            n_checks++;
            if (data_out !== pat[i % W]) begin
                n_fail++;
                $display("FAIL frame_a data_out bit %0d actual=%b required=%b", i, data_out, pat[i % W]);
            end
            n_checks++;
            if (frame_done !== ((i % W) == W - 1)) begin
                n_fail++;
                $display("FAIL frame_a frame_done bit %0d actual=%b required=%b", i, frame_done, (i % W) == W - 1);
            end
            tick();
        end
    endtask

    task automatic test_frame_b();
        logic [W-1:0] pat = 32'h9;
        sel = 1'b1;
        for (int i = 0; i < W; i++) begin
            #1;
            n_checks++;
            if (data_out !== pat[i] || frame_done !== (i == W - 1)) begin
                n_fail++;
                $display("FAIL frame_b bit %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, pat[i], i == W - 1);
            end
            tick();
        end
        // Frame A was frozen at position 0 while B shifted.
        sel = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_a_frozen actual=%b/%b required=1/0", data_out, frame_done);
        end
    endtask

    task automatic test_mid_switch();
        load = 1'b1;
        rA   = 32'hB;
        rB   = 32'h9;
        tick();
        load = 1'b0;
        sel  = 1'b0;
        repeat (2) tick();
        sel = 1'b1;
        repeat (3) tick();
        sel = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_switch resume_a actual=%b required=0", data_out);
        end
        // Finish frame A from index 2, then resume B from index 3.
        for (int i = 0; i < W - 2; i++) begin
            #1;
            n_checks++;
            if (data_out !== m_data() || frame_done !== m_done()) begin
                n_fail++;
                $display("FAIL mid_switch frame_a step %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, m_data(), m_done());
            end
            tick();
        end
        sel = 1'b1;
        for (int i = 0; i < W - 3; i++) begin
            #1;
            n_checks++;
            if (data_out !== m_data() || frame_done !== (i == W - 4)) begin
                n_fail++;
                $display("FAIL mid_switch frame_b step %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, m_data(), i == W - 4);
            end
            tick();
        end
    endtask

    task automatic test_load_mid();
        load = 1'b1;
        rA   = 32'hB;
        rB   = $urandom;
        sel  = 1'b0;
        tick();
        load = 1'b0;
        repeat (5) tick();
        load = 1'b1;
        rA   = 32'h8000_0001;
        #1;
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_mid frame_done_during_load actual=%b required=0", frame_done);
        end
        tick();
        load = 1'b0;
        for (int i = 0; i < W; i++) begin
            #1;
            n_checks++;
            if (data_out !== (i == 0 || i == W - 1) || frame_done !== (i == W - 1)) begin
                n_fail++;
                $display("FAIL load_mid bit %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, i == 0 || i == W - 1, i == W - 1);
            end
            tick();
        end
    endtask

    task automatic test_load_hold();
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rA  = $urandom;
            rB  = $urandom;
            sel = 1'($urandom_range(0, 1));
            tick();
            #1;
            n_checks++;
            if (data_out !== m_data() || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL load_hold cycle %0d actual=%b/%b required=%b/0", i, data_out, frame_done, m_data());
            end
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (data_out !== m_data() || frame_done !== m_done()) begin
                n_fail++;
                $display("FAIL load_hold shift %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, m_data(), m_done());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1;
        rA   = $urandom | 32'h3F;
        rB   = $urandom | 32'h1;
        sel  = 1'b0;
        tick();
        load = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (data_out !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset outputs actual=%b/%b required=0/0", data_out, frame_done);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (data_out !== 1'b0 || frame_done !== m_done()) begin
                n_fail++;
                $display("FAIL async_reset after_release %0d actual=%b/%b required=0/%b", i, data_out, frame_done, m_done());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 19) == 0);
            sel  = (($urandom_range(0, 7)) == 0) ? ~sel : sel;
            rA   = $urandom;
            rB   = $urandom;
            #1;
            n_checks++;
            if (data_out !== m_data() || frame_done !== m_done()) begin
                n_fail++;
                $display("FAIL random cycle %0d actual=%b/%b required=%b/%b", i, data_out, frame_done, m_data(), m_done());
            end
            tick();
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_frame_a();
        test_frame_b();
        test_mid_switch();
        test_load_mid();
        test_load_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
